// File: rtl/btn5_seq_reader.sv
// Five-button chase-order checker: sync, debounce and rising-edge detect per button,
// then a step tracker that expects presses 0..4 with an idle timeout between presses.

module btn5_db_bit #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic db_o,
  output logic rise_o
);
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q, db_q, db_dly_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s;

  assign s = ~s2_q;

  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (s == db_q)
      cnt_d = '0;
    else if (cnt_q == CNT_MAX) begin
      db_d  = s;
      cnt_d = '0;
    end else
      cnt_d = cnt_q + 1'b1;
  end

  // Sync flops reset to 1 so a held button looks released until it re-synchronizes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= btn_n_i;
      s2_q     <= s1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q    <= cnt_d;
    end
  end

  assign db_o   = db_q;
  assign rise_o = db_q & ~db_dly_q;
endmodule

module btn5_seq_reader #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TIMEOUT_CYCLES  = 250000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_n,
  output logic [4:0] btn_db,
  output logic       press_valid,
  output logic [2:0] press_code,
  output logic [2:0] step,
  output logic       seq_ok,
  output logic       seq_err,
  output logic [4:0] led
);
  localparam int NUM_BTN = 5;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] CODE_MULTI = 3'd7;
  localparam logic [2:0] LAST_STEP  = 3'd4;

  logic [NUM_BTN-1:0] rise;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn5_db_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
      .clk     (clk),
      .rst     (rst),
      .btn_n_i (btn_n[g]),
      .db_o    (btn_db[g]),
      .rise_o  (rise[g])
    );
  end

  logic          rise_any, rise_multi;
  logic [2:0]    rise_idx;
  logic          pv_q, pv_d, ok_q, ok_d, err_q, err_d;
  logic [2:0]    code_q, code_d;
  logic [2:0]    step_q, step_d;
  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    rise_idx = 3'd0;
    for (int i = 0; i < NUM_BTN; i++)
      if (rise[i]) rise_idx = 3'(i);
  end

  assign rise_any   = |rise;
  assign rise_multi = |(rise & (rise - 1'b1));

  // State register: step_q is the EXPECT state (next button index).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= 3'd0;
      tmo_q  <= '0;
      pv_q   <= 1'b0;
      code_q <= 3'd0;
      ok_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      step_q <= step_d;
      tmo_q  <= tmo_d;
      pv_q   <= pv_d;
      code_q <= code_d;
      ok_q   <= ok_d;
      err_q  <= err_d;
    end
  end

  // A press takes priority over a timeout expiring in the same cycle.
  always_comb begin
    step_d = step_q;
    tmo_d  = tmo_q;
    ok_d   = 1'b0;
    err_d  = 1'b0;
    pv_d   = rise_any;
    code_d = code_q;
    if (rise_any) begin
      code_d = rise_multi ? CODE_MULTI : rise_idx;
      tmo_d  = '0;
      if (!rise_multi && rise_idx == step_q) begin
        if (step_q == LAST_STEP) begin
          ok_d   = 1'b1;
          step_d = 3'd0;
        end else
          step_d = step_q + 3'd1;
      end else begin
        err_d  = 1'b1;
        step_d = 3'd0;
      end
    end else if (step_q == 3'd0)
      tmo_d = '0;
    else if (tmo_q == TMO_MAX) begin
      err_d  = 1'b1;
      step_d = 3'd0;
      tmo_d  = '0;
    end else
      tmo_d = tmo_q + 1'b1;
  end

  always_comb begin
    press_valid = pv_q;
    press_code  = code_q;
    step        = step_q;
    seq_ok      = ok_q;
    seq_err     = err_q;
    for (int i = 0; i < NUM_BTN; i++)
      led[i] = (3'(i) < step_q);
  end
endmodule

// File: tb/tb_btn5_seq_reader.sv
// Directed bench for btn5_seq_reader with short debounce/timeout so every
// latency can be checked cycle-exactly.

module tb_btn5_seq_reader;
  localparam int DB = 4;
  localparam int TO = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn_n = 5'b00000;
  logic [4:0] btn_db, led;
  logic       press_valid, seq_ok, seq_err;
  logic [2:0] press_code, step;

  int total = 0, bad = 0;
  int pv_cnt = 0, ok_cnt = 0, err_cnt = 0, both_cnt = 0;

  btn5_seq_reader #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_n       (btn_n),
    .btn_db      (btn_db),
    .press_valid (press_valid),
    .press_code  (press_code),
    .step        (step),
    .seq_ok      (seq_ok),
    .seq_err     (seq_err),
    .led         (led)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (press_valid) pv_cnt++;
      if (seq_ok) ok_cnt++;
      if (seq_err) err_cnt++;
      if (seq_ok && seq_err) both_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Press mask from the current negedge; expect the event on the 7th negedge.
  task automatic do_press(input logic [4:0] mask, input string tag, input int exp_code,
                          input int exp_step, input int exp_led, input int exp_ok,
                          input int exp_err);
    int lat;
    lat = 0;
    btn_n = ~mask;
    do begin
      @(negedge clk);
      lat++;
    end while (!press_valid && lat < 20);
    chk({tag, "_lat"},  lat, 7);
    chk({tag, "_code"}, press_code, exp_code);
    chk({tag, "_step"}, step, exp_step);
    chk({tag, "_led"},  led, exp_led);
    chk({tag, "_ok"},   seq_ok, exp_ok);
    chk({tag, "_err"},  seq_err, exp_err);
  endtask

  task automatic rel(input int hold, input int gap);
    repeat (hold) @(negedge clk);
    btn_n = 5'h1f;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int exp_step[5] = '{1, 2, 3, 4, 0};
    int exp_led[5]  = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b00000};
    int lat, k, p0, e0;
    logic flag;

    // Reset with all buttons held, then release reset.
    repeat (3) @(negedge clk);
    chk("rst_db", btn_db, 0);
    chk("rst_pv", press_valid, 0);
    chk("rst_code", press_code, 0);
    chk("rst_step", step, 0);
    chk("rst_ok", seq_ok, 0);
    chk("rst_err", seq_err, 0);
    chk("rst_led", led, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rel_db5", btn_db, 5'h00);
    @(negedge clk);
    chk("rel_db6", btn_db, 5'h1f);
    @(negedge clk);
    chk("rel_pv", press_valid, 1);
    chk("rel_code", press_code, 7);
    chk("rel_err", seq_err, 1);
    chk("rel_ok", seq_ok, 0);
    chk("rel_step", step, 0);
    @(negedge clk);
    chk("rel_pv_once", press_valid, 0);
    btn_n = 5'h1f;
    repeat (15) @(negedge clk);

    // Clean chase 0..4.
    for (int i = 0; i < 5; i++) begin
      do_press(5'(1 << i), $sformatf("chase%0d", i), i, exp_step[i], exp_led[i],
               (i == 4) ? 1 : 0, 0);
      rel(3, 10);
    end

    // Bounce on button 2.
    p0 = pv_cnt;
    flag = 1'b0;
    for (int r = 0; r < 5; r++) begin
      btn_n = ~5'b00100;
      repeat (3) begin
        @(negedge clk);
        if (btn_db != 5'h00) flag = 1'b1;
      end
      btn_n = 5'h1f;
      @(negedge clk);
      if (btn_db != 5'h00) flag = 1'b1;
    end
    btn_n = ~5'b00100;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (btn_db[2] == 1'b0 && lat < 20);
    chk("bounce_quiet", flag, 0);
    chk("bounce_db_lat", lat, 6);
    @(negedge clk);
    chk("bounce_pv", press_valid, 1);
    chk("bounce_code", press_code, 2);
    rel(3, 10);
    chk("bounce_pv_cnt", pv_cnt - p0, 1);

    // Wrong press from step 2, then restart.
    do_press(5'b00001, "w0", 0, 1, 5'b00001, 0, 0);
    rel(3, 10);
    do_press(5'b00010, "w1", 1, 2, 5'b00011, 0, 0);
    rel(3, 10);
    do_press(5'b10000, "wrong4", 4, 0, 5'b00000, 0, 1);
    rel(3, 10);
    do_press(5'b00001, "restart", 0, 1, 5'b00001, 0, 0);
    rel(3, 10);
    do_press(5'b00010, "restart1", 1, 2, 5'b00011, 0, 0);
    rel(3, 60);
    chk("idle_to_step", step, 0);

    // Timeout 50 cycles after the press event.
    do_press(5'b00001, "to_start", 0, 1, 5'b00001, 0, 0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 3) btn_n = 5'h1f;
    end while (!seq_err && k < 70);
    chk("to_lat", k, 50);
    chk("to_step", step, 0);
    chk("to_led", led, 0);
    repeat (10) @(negedge clk);

    // Press landing on the expiry cycle wins.
    do_press(5'b00001, "co_start", 0, 1, 5'b00001, 0, 0);
    repeat (3) @(negedge clk);
    btn_n = 5'h1f;
    repeat (40) @(negedge clk);
    e0 = err_cnt;
    do_press(5'b00010, "co_press", 1, 2, 5'b00011, 0, 0);
    rel(3, 10);
    chk("co_noerr", err_cnt - e0, 0);

    // Finish the chase from step 2.
    do_press(5'b00100, "f2", 2, 3, 5'b00111, 0, 0);
    rel(3, 10);
    do_press(5'b01000, "f3", 3, 4, 5'b01111, 0, 0);
    rel(3, 10);
    do_press(5'b10000, "f4", 4, 0, 5'b00000, 1, 0);
    rel(3, 10);

    // Long hold of button 1 gives one event; release gives none.
    do_press(5'b00001, "h0", 0, 1, 5'b00001, 0, 0);
    rel(3, 10);
    p0 = pv_cnt;
    do_press(5'b00010, "hold1", 1, 2, 5'b00011, 0, 0);
    repeat (193) @(negedge clk);
    btn_n = 5'h1f;
    repeat (20) @(negedge clk);
    chk("hold_pv_cnt", pv_cnt - p0, 1);

    // Reset mid-operation with button 3 held.
    do_press(5'b01000, "r_pre", 3, 0, 5'b00000, 0, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_db", btn_db, 0);
    chk("mid_rst_code", press_code, 0);
    chk("mid_rst_step", step, 0);
    @(negedge clk);
    rst = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!press_valid && lat < 20);
    chk("mid_rel_lat", lat, 7);
    chk("mid_rel_code", press_code, 3);
    rel(3, 10);

    chk("ok_cnt", ok_cnt, 2);
    chk("ok_err_excl", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
